// File: rtl/move_pkg.sv
// Shared constants for the character movement block: vertical state
// encoding and bit positions inside the key and collision vectors.
package move_pkg;

  // Vertical state encoding, kept as plain constants so older code that
  // compares the state output against integers keeps working.
  localparam logic [1:0] ST_GROUND = 2'd0;
  localparam logic [1:0] ST_RISE   = 2'd1;
  localparam logic [1:0] ST_FALL   = 2'd2;

  // Key vector bit positions (w/a/s/d).
  localparam int KEY_JUMP  = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_RIGHT = 3;

  // Collision vector bit positions, as produced by the collision unit.
  localparam int COL_FLOOR = 0;
  localparam int COL_CEIL  = 1;
  localparam int COL_RIGHT = 2;
  localparam int COL_LEFT  = 3;

endpackage

// File: rtl/move_vert.sv
// Vertical motion of one character: GROUND/RISE/FALL state machine,
// signed vertical speed with fall-speed saturation, and the y clamp.
// Optional build macro: DOUBLE_JUMP_EN adds one extra jump while airborne.
module move_vert
  import move_pkg::*;
#(
  parameter int Y_W      = 9,
  parameter int V_W      = 9,
  parameter int GRAVITY  = 1,
  parameter int JUMP_V   = 14,
  parameter int MAX_FALL = 14,
  parameter int Y_MAX    = 479
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_tick,
  input  logic                  i_spawn,
  input  logic [Y_W-1:0]        i_spawn_y,
  input  logic                  i_jump_edge,
  input  logic                  i_col_floor,
  input  logic                  i_col_ceil,
  output logic [Y_W-1:0]        o_y,
  output logic signed [V_W-1:0] o_v,
  output logic [1:0]            o_state,
  output logic                  o_jump_pulse
);

  // The y sum is widened beyond Y_W+1 so that a large downward speed near
  // the bottom edge saturates at Y_MAX instead of wrapping.
  localparam int YW2 = ((Y_W > V_W) ? Y_W : V_W) + 2;

  localparam logic signed [V_W:0]     C_GRAV  = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]     C_MIN_V = (V_W+1)'(-MAX_FALL);
  localparam logic signed [V_W-1:0]   C_JUMP  = V_W'(JUMP_V);
  localparam logic signed [YW2-1:0]   C_YMAX  = YW2'(Y_MAX);

  logic [Y_W-1:0]        r_y;
  logic signed [V_W-1:0] r_v;
  logic [1:0]            r_state;
  logic                  r_pulse;
`ifdef DOUBLE_JUMP_EN
  logic                  r_air_used;
  logic                  w_air_next;
`endif

  logic signed [V_W:0]   w_v_dec;
  logic signed [V_W:0]   w_v_lim;
  logic signed [V_W-1:0] w_v_sat;
  logic                  w_v_le0;
  logic signed [V_W-1:0] w_v_next;
  logic [1:0]            w_state_next;
  logic                  w_pulse;
  logic signed [YW2-1:0] w_y_calc;
  logic [Y_W-1:0]        w_y_next;

  // Gravity step one bit wider than the speed so the subtraction cannot
  // wrap, then limited to the terminal fall speed.
  assign w_v_dec = signed'({r_v[V_W-1], r_v}) - C_GRAV;
  assign w_v_lim = (w_v_dec < C_MIN_V) ? C_MIN_V : w_v_dec;
  assign w_v_sat = w_v_lim[V_W-1:0];
  assign w_v_le0 = w_v_lim[V_W] || (w_v_lim == '0);

  // Next speed, state and jump strobe for the coming tick.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    w_v_next     = r_v;
    w_state_next = r_state;
    w_pulse      = 1'b0;
`ifdef DOUBLE_JUMP_EN
    w_air_next   = r_air_used;
`endif
    case (r_state)
      ST_GROUND: begin
        if (i_jump_edge && !i_col_ceil) begin
          w_v_next     = C_JUMP;
          w_state_next = ST_RISE;
          w_pulse      = 1'b1;
        end else begin
          w_v_next = '0;
          if (!i_col_floor) w_state_next = ST_FALL;
        end
      end
      ST_RISE: begin
        if (i_col_ceil) begin
          w_v_next     = '0;
          w_state_next = ST_FALL;
`ifdef DOUBLE_JUMP_EN
        end else if (i_jump_edge && !r_air_used) begin
          w_v_next     = C_JUMP;
          w_pulse      = 1'b1;
          w_air_next   = 1'b1;
`endif
        end else begin
          w_v_next = w_v_sat;
          if (w_v_le0) w_state_next = ST_FALL;
        end
      end
      ST_FALL: begin
        // Landing outranks a simultaneous jump edge; the jump needs a new edge.
        if (i_col_floor) begin
          w_v_next     = '0;
          w_state_next = ST_GROUND;
`ifdef DOUBLE_JUMP_EN
          w_air_next   = 1'b0;
`endif
`ifdef DOUBLE_JUMP_EN
        end else if (i_jump_edge && !r_air_used) begin
          w_v_next     = C_JUMP;
          w_state_next = ST_RISE;
          w_pulse      = 1'b1;
          w_air_next   = 1'b1;
`endif
        end else begin
          w_v_next = w_v_sat;
        end
      end
      default: begin
        w_v_next     = '0;
        w_state_next = ST_FALL;
      end
    endcase
  end

  // y moves opposite to speed (screen y grows downward), clamped on screen.
  assign w_y_calc = signed'(YW2'(r_y)) - YW2'(w_v_next);

  // Clamp the new y to [0, Y_MAX]; hitting Y_MAX is not a landing.
  always_comb begin
    if (w_y_calc[YW2-1])        w_y_next = '0;
    else if (w_y_calc > C_YMAX) w_y_next = Y_W'(Y_MAX);
    else                        w_y_next = w_y_calc[Y_W-1:0];
  end

  // Vertical registers: reset, then spawn load, then per-tick update.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (reset) begin
      r_y        <= '0;
      r_v        <= '0;
      r_state    <= ST_FALL;
      r_pulse    <= 1'b0;
`ifdef DOUBLE_JUMP_EN
      r_air_used <= 1'b0;
`endif
    end else if (i_spawn) begin
      r_y        <= i_spawn_y;
      r_v        <= '0;
      r_state    <= ST_FALL;
      r_pulse    <= 1'b0;
`ifdef DOUBLE_JUMP_EN
      r_air_used <= 1'b0;
`endif
    end else if (i_tick) begin
      r_y        <= w_y_next;
      r_v        <= w_v_next;
      r_state    <= w_state_next;
      r_pulse    <= w_pulse;
`ifdef DOUBLE_JUMP_EN
      r_air_used <= w_air_next;
`endif
    end else begin
      r_pulse    <= 1'b0;
    end
  end

  assign o_y          = r_y;
  assign o_v          = r_v;
  assign o_state      = r_state;
  assign o_jump_pulse = r_pulse;

endmodule

// File: rtl/move_player.sv
// Per-character movement: horizontal stepping with clamping and blocking,
// facing direction, jump edge detection, and the vertical sub-block.
// Optional build macro: DOUBLE_JUMP_EN (handled inside move_vert).
module move_player
  import move_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int V_W      = 9,
  parameter int STEP_X   = 1,
  parameter int GRAVITY  = 1,
  parameter int JUMP_V   = 14,
  parameter int MAX_FALL = 14,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [3:0]            keys,
  input  logic [3:0]            collision,
  input  logic                  spawn,
  input  logic [X_W-1:0]        spawn_x,
  input  logic [Y_W-1:0]        spawn_y,
  output logic [X_W-1:0]        x_pos,
  output logic [Y_W-1:0]        y_pos,
  output logic signed [V_W-1:0] v_speed,
  output logic [1:0]            state,
  output logic                  facing_left,
  output logic                  moving,
  output logic                  jump_pulse
);

  localparam logic [X_W-1:0] C_STEP   = X_W'(STEP_X);
  localparam logic [X_W:0]   C_XMAX_W = (X_W+1)'(X_MAX);

  logic [X_W-1:0] r_x;
  logic           r_facing;
  logic           r_moving;
  logic           r_jump_prev;

  logic           w_left;
  logic           w_right;
  logic           w_jump_edge;
  logic [X_W:0]   w_x_sum;
  logic [X_W-1:0] w_x_next;
  logic           w_facing_next;
  logic           w_unused_down;

  // The down key has no effect on this block.
  assign w_unused_down = keys[KEY_DOWN];

  assign w_left      = keys[KEY_LEFT] && !keys[KEY_RIGHT];
  assign w_right     = keys[KEY_RIGHT] && !keys[KEY_LEFT];
  assign w_jump_edge = keys[KEY_JUMP] && !r_jump_prev;
  assign w_x_sum     = {1'b0, r_x} + (X_W+1)'(STEP_X);

  // Horizontal step: floor at 0, cap at X_MAX, hold when blocked; facing
  // follows the pressed key even when the move itself is blocked.
  always_comb begin
    w_x_next      = r_x;
    w_facing_next = r_facing;
    if (w_left) begin
      w_facing_next = 1'b1;
      if (!collision[COL_LEFT])
        w_x_next = (r_x < C_STEP) ? '0 : r_x - C_STEP;
    end else if (w_right) begin
      w_facing_next = 1'b0;
      if (!collision[COL_RIGHT])
        w_x_next = (w_x_sum > C_XMAX_W) ? C_XMAX_W[X_W-1:0] : w_x_sum[X_W-1:0];
    end
  end

  // Horizontal registers and jump history: reset, spawn load, tick update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x         <= '0;
      r_facing    <= 1'b0;
      r_moving    <= 1'b0;
      r_jump_prev <= 1'b0;
    end else if (spawn) begin
      r_x         <= spawn_x;
      r_moving    <= 1'b0;
      r_jump_prev <= keys[KEY_JUMP];
    end else if (tick) begin
      r_x         <= w_x_next;
      r_facing    <= w_facing_next;
      r_moving    <= (w_x_next != r_x);
      r_jump_prev <= keys[KEY_JUMP];
    end
  end

  move_vert #(
    .Y_W      (Y_W),
    .V_W      (V_W),
    .GRAVITY  (GRAVITY),
    .JUMP_V   (JUMP_V),
    .MAX_FALL (MAX_FALL),
    .Y_MAX    (Y_MAX)
  ) u_vert (
    .clk          (clk),
    .reset        (reset),
    .i_tick       (tick),
    .i_spawn      (spawn),
    .i_spawn_y    (spawn_y),
    .i_jump_edge  (w_jump_edge),
    .i_col_floor  (collision[COL_FLOOR]),
    .i_col_ceil   (collision[COL_CEIL]),
    .o_y          (y_pos),
    .o_v          (v_speed),
    .o_state      (state),
    .o_jump_pulse (jump_pulse)
  );

  assign x_pos       = r_x;
  assign facing_left = r_facing;
  assign moving      = r_moving;

endmodule

// File: tb/tb_move_player.sv
// Directed bench for move_player: a table of single-cycle vectors followed
// by hand-written jump, fall, ceiling and double-jump sequences.
module tb_move_player;
  import move_pkg::*;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int V_W = 9;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  tick;
  logic [3:0]            keys;
  logic [3:0]            collision;
  logic                  spawn;
  logic [X_W-1:0]        spawn_x;
  logic [Y_W-1:0]        spawn_y;
  logic [X_W-1:0]        x_pos;
  logic [Y_W-1:0]        y_pos;
  logic signed [V_W-1:0] v_speed;
  logic [1:0]            state;
  logic                  facing_left;
  logic                  moving;
  logic                  jump_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int GND  = 0;
  localparam int RISE = 1;
  localparam int FALL = 2;

  move_player dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .keys        (keys),
    .collision   (collision),
    .spawn       (spawn),
    .spawn_x     (spawn_x),
    .spawn_y     (spawn_y),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .v_speed     (v_speed),
    .state       (state),
    .facing_left (facing_left),
    .moving      (moving),
    .jump_pulse  (jump_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sp;
    int         sx;
    int         sy;
    logic [3:0] k;
    logic [3:0] c;
    logic       tk;
    int         ex;
    int         ey;
    int         ev;
    int         est;
    int         ef;
    int         em;
    int         ep;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sp, input int sx, input int sy,
                     input logic [3:0] k, input logic [3:0] c, input logic tk,
                     input int ex, input int ey, input int ev, input int est,
                     input int ef, input int em, input int ep);
    vec_t v;
    v.sp = sp; v.sx = sx; v.sy = sy; v.k = k; v.c = c; v.tk = tk;
    v.ex = ex; v.ey = ey; v.ev = ev; v.est = est; v.ef = ef; v.em = em; v.ep = ep;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and sample 1 ns after the rising edge.
  task automatic drive(input logic sp, input int sx, input int sy,
                       input logic [3:0] k, input logic [3:0] c, input logic tk);
    spawn     = sp;
    spawn_x   = X_W'(sx);
    spawn_y   = Y_W'(sy);
    keys      = k;
    collision = c;
    tick      = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int ex, input int ey,
                           input int ev, input int est, input int ef,
                           input int em, input int ep);
    check({tag, ".x"},      int'(x_pos),       ex);
    check({tag, ".y"},      int'(y_pos),       ey);
    check({tag, ".v"},      int'(v_speed),     ev);
    check({tag, ".state"},  int'(state),       est);
    check({tag, ".facing"}, int'(facing_left), ef);
    check({tag, ".moving"}, int'(moving),      em);
    check({tag, ".pulse"},  int'(jump_pulse),  ep);
  endtask

  task automatic check_vert(input string tag, input int ey, input int ev,
                            input int est, input int ep);
    check({tag, ".y"},     int'(y_pos),      ey);
    check({tag, ".v"},     int'(v_speed),    ev);
    check({tag, ".state"}, int'(state),      est);
    check({tag, ".pulse"}, int'(jump_pulse), ep);
  endtask

  // Absolute bound on run time in case the sequence ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ye;
    int ve;

    // ---------------- vector table ----------------
    //   sp  sx   sy   keys     col      tk   x    y    v   state fl mv pl
    add(1, 100, 200, 4'b0000, 4'b0001, 0, 100, 200,  0, FALL, 0, 0, 0); // spawn
    add(0,   0,   0, 4'b1000, 4'b0001, 1, 101, 200,  0, GND,  0, 1, 0); // land + right
    add(0,   0,   0, 4'b1000, 4'b0001, 0, 101, 200,  0, GND,  0, 1, 0); // no tick: hold
    add(0,   0,   0, 4'b1000, 4'b0001, 1, 102, 200,  0, GND,  0, 1, 0);
    add(0,   0,   0, 4'b1000, 4'b0001, 1, 103, 200,  0, GND,  0, 1, 0);
    add(0,   0,   0, 4'b1000, 4'b0001, 1, 104, 200,  0, GND,  0, 1, 0);
    add(0,   0,   0, 4'b1000, 4'b0001, 1, 105, 200,  0, GND,  0, 1, 0); // 5 ticks right
    add(0,   0,   0, 4'b0000, 4'b0001, 1, 105, 200,  0, GND,  0, 0, 0); // no key
    add(0,   0,   0, 4'b0010, 4'b1001, 1, 105, 200,  0, GND,  1, 0, 0); // left blocked
    add(0,   0,   0, 4'b1010, 4'b0001, 1, 105, 200,  0, GND,  1, 0, 0); // both keys
    add(0,   0,   0, 4'b1000, 4'b0101, 1, 105, 200,  0, GND,  0, 0, 0); // right blocked
    add(1,   0, 100, 4'b0000, 4'b0000, 0,   0, 100,  0, FALL, 0, 0, 0); // spawn x=0
    add(0,   0,   0, 4'b0010, 4'b0001, 1,   0, 100,  0, GND,  1, 0, 0); // left at 0
    add(0,   0,   0, 4'b1000, 4'b0001, 1,   1, 100,  0, GND,  0, 1, 0);
    add(0,   0,   0, 4'b0010, 4'b0001, 1,   0, 100,  0, GND,  1, 1, 0);
    add(1, 639,  50, 4'b0000, 4'b0000, 0, 639,  50,  0, FALL, 1, 0, 0); // spawn at X_MAX
    add(0,   0,   0, 4'b1000, 4'b0001, 1, 639,  50,  0, GND,  0, 0, 0); // right capped
    add(0,   0,   0, 4'b0010, 4'b0001, 1, 638,  50,  0, GND,  1, 1, 0);
    add(1,  50, 100, 4'b0000, 4'b0000, 0,  50, 100,  0, FALL, 1, 0, 0);
    add(0,   0,   0, 4'b1000, 4'b0101, 1,  50, 100,  0, GND,  0, 0, 0); // right blocked
    add(0,   0,   0, 4'b0010, 4'b1001, 1,  50, 100,  0, GND,  1, 0, 0); // left blocked
    add(1,   7,   8, 4'b1000, 4'b0001, 1,   7,   8,  0, FALL, 1, 0, 0); // spawn beats tick
    add(0,   0,   0, 4'b0000, 4'b0001, 1,   7,   8,  0, GND,  1, 0, 0);
    add(0,   0,   0, 4'b0001, 4'b0000, 1,   7,   0, 14, RISE, 1, 0, 1); // jump, y clamps at 0
    add(0,   0,   0, 4'b0001, 4'b0000, 0,   7,   0, 14, RISE, 1, 0, 0); // pulse one cycle
    add(1,   7,   8, 4'b0001, 4'b0000, 0,   7,   8,  0, FALL, 1, 0, 0); // spawn, jump held
    add(0,   0,   0, 4'b0001, 4'b0001, 1,   7,   8,  0, GND,  1, 0, 0); // no edge
    add(0,   0,   0, 4'b0001, 4'b0001, 1,   7,   8,  0, GND,  1, 0, 0);
    add(1,   7,   8, 4'b0000, 4'b0000, 0,   7,   8,  0, FALL, 1, 0, 0);
    add(0,   0,   0, 4'b0001, 4'b0001, 1,   7,   8,  0, GND,  1, 0, 0); // land beats jump
    add(0,   0,   0, 4'b0001, 4'b0001, 1,   7,   8,  0, GND,  1, 0, 0); // needs new edge
    add(1,   7, 475, 4'b0000, 4'b0000, 0,   7, 475,  0, FALL, 1, 0, 0);
    add(0,   0,   0, 4'b0000, 4'b0000, 1,   7, 476, -1, FALL, 1, 0, 0);
    add(0,   0,   0, 4'b0000, 4'b0000, 1,   7, 478, -2, FALL, 1, 0, 0);
    add(0,   0,   0, 4'b0000, 4'b0000, 1,   7, 479, -3, FALL, 1, 0, 0); // y clamps at Y_MAX
    add(0,   0,   0, 4'b0000, 4'b0000, 1,   7, 479, -4, FALL, 1, 0, 0); // no landing
    add(0,   0,   0, 4'b0000, 4'b0001, 1,   7, 479,  0, GND,  1, 0, 0);
    add(0,   0,   0, 4'b0000, 4'b0000, 1,   7, 479,  0, FALL, 1, 0, 0); // walk off
    add(0,   0,   0, 4'b0000, 4'b0001, 1,   7, 479,  0, GND,  1, 0, 0);
    add(0,   0,   0, 4'b0001, 4'b0011, 1,   7, 479,  0, GND,  1, 0, 0); // ceiling blocks jump
    add(0,   0,   0, 4'b0000, 4'b0001, 1,   7, 479,  0, GND,  1, 0, 0);

    // ---------------- reset ----------------
    reset = 1'b1;
    drive(0, 0, 0, 4'b0000, 4'b0000, 0);
    drive(0, 0, 0, 4'b0000, 4'b0000, 0);
    check_all("reset", 0, 0, 0, FALL, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].sp, vecs[i].sx, vecs[i].sy, vecs[i].k, vecs[i].c, vecs[i].tk);
      check_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ev,
                vecs[i].est, vecs[i].ef, vecs[i].em, vecs[i].ep);
    end

    // ---------------- full jump arc, then free fall ----------------
    drive(1, 100, 200, 4'b0000, 4'b0001, 0);
    drive(0, 0, 0, 4'b0000, 4'b0001, 1);
    check_vert("arc_gnd", 200, 0, GND, 0);
    drive(0, 0, 0, 4'b0001, 4'b0000, 1);
    check_vert("arc_t1", 186, 14, RISE, 1);
    drive(0, 0, 0, 4'b0001, 4'b0000, 0);
    check_vert("arc_idle", 186, 14, RISE, 0);
    ye = 186;
    for (int k = 2; k <= 15; k++) begin
      drive(0, 0, 0, 4'b0001, 4'b0000, 1);
      ve = 15 - k;
      ye = ye - ve;
      check_vert($sformatf("arc_t%0d", k), ye, ve, (k == 15) ? FALL : RISE, 0);
    end
    check("arc_apex_y", int'(y_pos), 95);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 4'b0000, 4'b0000, 1);
      ve = (ve - 1 < -14) ? -14 : ve - 1;
      ye = ye - ve;
      check_vert($sformatf("fall_t%0d", k), ye, ve, FALL, 0);
    end
    check("fall_end_v", int'(v_speed), -14);
    check("fall_end_y", int'(y_pos), 284);
    drive(0, 0, 0, 4'b0000, 4'b0001, 1);
    check_vert("land", 284, 0, GND, 0);
    drive(0, 0, 0, 4'b0000, 4'b0001, 1);
    check_vert("land_hold", 284, 0, GND, 0);

    // ---------------- ceiling hit while rising at v=10 ----------------
    drive(0, 0, 0, 4'b0001, 4'b0000, 1);
    check_vert("ceil_t1", 270, 14, RISE, 1);
    ye = 270;
    for (int k = 2; k <= 5; k++) begin
      drive(0, 0, 0, 4'b0001, 4'b0000, 1);
      ve = 15 - k;
      ye = ye - ve;
    end
    check_vert("ceil_v10", 224, 10, RISE, 0);
    drive(0, 0, 0, 4'b0001, 4'b0011, 1);
    check_vert("ceil_hit", 224, 0, FALL, 0);
    drive(0, 0, 0, 4'b0000, 4'b0001, 1);
    check_vert("ceil_land", 224, 0, GND, 0);

    // ---------------- mid-air jump edges ----------------
    ye = 224;
    drive(0, 0, 0, 4'b0001, 4'b0000, 1);
    ye = ye - 14;
    check_vert("dj_first", ye, 14, RISE, 1);
    drive(0, 0, 0, 4'b0000, 4'b0000, 1);
    ye = ye - 13;
    check_vert("dj_rel1", ye, 13, RISE, 0);
    drive(0, 0, 0, 4'b0001, 4'b0000, 1);
`ifdef DOUBLE_JUMP_EN
    ye = ye - 14;
    check_vert("dj_second", ye, 14, RISE, 1);
    ve = 14;
`else
    ye = ye - 12;
    check_vert("dj_second", ye, 12, RISE, 0);
    ve = 12;
`endif
    drive(0, 0, 0, 4'b0000, 4'b0000, 1);
    ve = ve - 1;
    ye = ye - ve;
    check_vert("dj_rel2", ye, ve, RISE, 0);
    drive(0, 0, 0, 4'b0001, 4'b0000, 1);
    ve = ve - 1;
    ye = ye - ve;
    check_vert("dj_third", ye, ve, RISE, 0);
    drive(0, 0, 0, 4'b0000, 4'b0010, 1);
    check_vert("dj_ceil", ye, 0, FALL, 0);
    drive(0, 0, 0, 4'b0000, 4'b0001, 1);
    check_vert("dj_land", ye, 0, GND, 0);
    drive(0, 0, 0, 4'b0001, 4'b0000, 1);
    ye = ye - 14;
    check_vert("dj_new_ground", ye, 14, RISE, 1);
    drive(0, 0, 0, 4'b0000, 4'b0000, 1);
    ye = ye - 13;
    check_vert("dj_rel3", ye, 13, RISE, 0);
    drive(0, 0, 0, 4'b0001, 4'b0000, 1);
`ifdef DOUBLE_JUMP_EN
    ye = ye - 14;
    check_vert("dj_after_land", ye, 14, RISE, 1);
`else
    ye = ye - 12;
    check_vert("dj_after_land", ye, 12, RISE, 0);
`endif

    // ---------------- reset outranks spawn and tick ----------------
    reset = 1'b1;
    drive(1, 300, 300, 4'b1001, 4'b0001, 1);
    check_all("reset2", 0, 0, 0, FALL, 0, 0, 0);
    reset = 1'b0;
    drive(0, 0, 0, 4'b0000, 4'b0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
